// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers
// used by the iterative encryption core and its round datapath.
package aes_pkg;

  localparam int NR         = 10;
  localparam int BLOCK_BITS = 128;
  localparam int KEY_BITS   = 128 * (NR + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // col[31:24] is row 0 of the column.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// Combinational AES encryption round:
// SubBytes -> ShiftRows -> MixColumns (skipped on final_round) -> AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] next_state
);

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [127:0] sr_flat;
  logic [127:0] mc_flat;

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      sb[i] = sbox(state[127 - 8*i -: 8]);
    end
  end

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end
  end

  always_comb begin
    sr_flat    = '0;
    mc_flat    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sr_flat[127 - 8*i -: 8] = sr[i];
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc_flat[127 - 32*c -: 32] = mix_column(sr_flat[127 - 32*c -: 32]);
    end
    next_state = (final_round ? sr_flat : mc_flat) ^ round_key;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core, one round per clock with valid/ready on both sides.
// Define AES_ENC_KEY_LATCH_EN to latch expanded_key on acceptance instead of reading it live.
module aes_encrypt_iter #(
  parameter int NR       = 10,
  parameter int KEY_BITS = 128 * (NR + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plain_text,
  input  logic [0:KEY_BITS-1] expanded_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        cipher_text,
  output logic                busy
);
  import aes_pkg::*;

  localparam logic [3:0]  LAST_ROUND = 4'(NR);
  localparam int unsigned NR_U       = NR;

  if (NR != 10 || KEY_BITS != 128 * (NR + 1)) begin : g_nr_check
    $error("aes_encrypt_iter supports only NR=10 with KEY_BITS=1408");
  end

  aes_state_e          state;
  logic [3:0]          round;
  logic [127:0]        s_q;
  logic [0:KEY_BITS-1] key_src;
  logic [127:0]        round_key;
  logic [127:0]        round_out;
  logic                final_round;
  logic                accept;

`ifdef AES_ENC_KEY_LATCH_EN
  logic [0:KEY_BITS-1] key_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
    end else if (accept) begin
      key_q <= expanded_key;
    end
  end

  assign key_src = key_q;
`else
  assign key_src = expanded_key;
`endif

  always_comb begin
    accept      = in_valid && in_ready;
    final_round = (round == LAST_ROUND);
    round_key   = '0;
    for (int unsigned r = 0; r <= NR_U; r++) begin
      if (round == 4'(r)) begin
        round_key = key_src[128*r +: 128];
      end
    end
  end

  aes_enc_round u_round (
    .state       (s_q),
    .round_key   (round_key),
    .final_round (final_round),
    .next_state  (round_out)
  );

  // Whitening uses expanded_key directly: a latched key is only valid after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      round       <= '0;
      s_q         <= '0;
      cipher_text <= '0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            s_q      <= plain_text ^ expanded_key[0:127];
            round    <= 4'd1;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (round == LAST_ROUND) begin
            cipher_text <= round_out;
            out_valid   <= 1'b1;
            round       <= '0;
            state       <= DONE;
          end else if (round != 4'd0 && round < LAST_ROUND) begin
            s_q   <= round_out;
            round <= round + 4'd1;
          end else begin
            round    <= '0;
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          round     <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter against a byte-level AES-128 model
// whose S-box is derived from GF(2^8) inverses and the affine map.
module tb_aes_encrypt_iter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [127:0]  plain_text = '0;
  logic [0:1407] expanded_key = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [127:0]  cipher_text;
  logic          busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  tb_sbox [256];

  aes_encrypt_iter #(.NR(10), .KEY_BITS(1408)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .plain_text   (plain_text),
    .expanded_key (expanded_key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .cipher_text  (cipher_text),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] rot;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s   = inv ^ 8'h63;
      rot = inv;
      for (int k = 0; k < 4; k++) begin
        rot = {rot[6:0], rot[7]};
        s ^= rot;
      end
      tb_sbox[x] = s;
    end
  endtask

  function automatic logic [0:1407] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [0:1407] ek;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
        t[31:24] ^= rcon;
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ek[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ek;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [0:1407] ek);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   kb;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      kb   = ek[8*i +: 8];
      s[i] = pt[127 - 8*i -: 8] ^ kb;
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = tb_sbox[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row + 4*col] = t[row + 4*((col + row) % 4)];
      if (rnd < 10) begin
        for (int col = 0; col < 4; col++) begin
          for (int row = 0; row < 4; row++) t[row] = s[4*col + row];
          for (int row = 0; row < 4; row++)
            s[4*col + row] = gmul(t[row], 8'h02) ^ gmul(t[(row+1)%4], 8'h03)
                           ^ t[(row+2)%4] ^ t[(row+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) begin
        kb   = ek[128*rnd + 8*i +: 8];
        s[i] = s[i] ^ kb;
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller #1 after the accepting edge.
  task automatic send(input string tag, input logic [127:0] pt, input logic [0:1407] ek);
    bit ok;
    ok           = 1'b0;
    plain_text   = pt;
    expanded_key = ek;
    in_valid     = 1'b1;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (ok) tick();
    in_valid = 1'b0;
    check({tag, "_accept"}, 128'(ok), 128'd1);
    check({tag, "_busy"}, 128'(busy), 128'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (out_valid) lat = k;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_low"}, 128'(out_valid), 128'd0);
    check({tag, "_ready"}, 128'(in_ready), 128'd1);
    check({tag, "_idle"}, 128'(busy), 128'd0);
  endtask

  task automatic run_block(input string tag, input logic [127:0] pt, input logic [0:1407] ek,
                           input logic [127:0] exp, input int stall);
    int lat;
    send(tag, pt, ek);
    wait_out(lat);
    check({tag, "_latency"}, 128'(lat), 128'd10);
    check({tag, "_ct"}, cipher_text, exp);
    for (int k = 0; k < stall; k++) begin
      tick();
      check({tag, "_hold"}, cipher_text, exp);
    end
    handshake(tag);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [0:1407] ek_c1;
    logic [0:1407] ek_b;
    logic [0:1407] ek_r;
    logic [127:0]  key_r;
    logic [127:0]  pt_r;
    logic [127:0]  pt_b2;
    logic [127:0]  ct1;
    int            lat;
    int            lat1;
    int            acc2;
    bit            prev_ready;
    bit            got1;

    build_sbox();
    ek_c1 = expand_key(C1_KEY);
    ek_b  = expand_key(B_KEY);

    repeat (3) tick();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_cipher", cipher_text, 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 128'(in_ready), 128'd1);

    run_block("c1", C1_PT, ek_c1, C1_CT, 0);
    run_block("appb", B_PT, ek_b, B_CT, 0);

    for (int i = 0; i < 12; i++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom};
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      ek_r  = expand_key(key_r);
      run_block($sformatf("rand%0d", i), pt_r, ek_r, ref_encrypt(pt_r, ek_r),
                int'($urandom_range(0, 3)));
    end

    // Back-pressure with ignored input pulses.
    send("bp", C1_PT, ek_c1);
    wait_out(lat);
    check("bp_latency", 128'(lat), 128'd10);
    for (int k = 0; k < 20; k++) begin
      in_valid   = k[0];
      plain_text = {$urandom, $urandom, $urandom, $urandom};
      tick();
      check("bp_hold_ct", cipher_text, C1_CT);
      check("bp_hold_ov", 128'(out_valid), 128'd1);
      check("bp_no_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    tick();
    check("bp_no_accept", 128'(busy), 128'd0);

    // Reset wins over a simultaneous valid input in IDLE.
    rst        = 1'b1;
    in_valid   = 1'b1;
    plain_text = B_PT;
    tick();
    check("rst_vs_valid_busy", 128'(busy), 128'd0);
    check("rst_vs_valid_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();

    // Reset in the middle of a run.
    send("mid", B_PT, ek_b);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_ov", 128'(out_valid), 128'd0);
    check("mid_rst_ct", cipher_text, 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_ready", 128'(in_ready), 128'd1);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("mid_no_partial", 128'(out_valid), 128'd0);
    end
    run_block("mid_after", B_PT, ek_b, B_CT, 0);

    // Back-to-back with out_ready tied high; both blocks share the C.1 key.
    pt_b2        = {$urandom, $urandom, $urandom, $urandom};
    out_ready    = 1'b1;
    plain_text   = C1_PT;
    expanded_key = ek_c1;
    in_valid     = 1'b1;
    got1         = 1'b0;
    for (int k = 0; k < 40 && !got1; k++) begin
      @(negedge clk);
      if (in_ready) got1 = 1'b1;
    end
    check("b2b_first_accept", 128'(got1), 128'd1);
    tick();
    plain_text = pt_b2;
    prev_ready = in_ready;
    acc2       = 0;
    lat1       = 0;
    ct1        = '0;
    got1       = 1'b0;
    for (int k = 1; k <= 30 && acc2 == 0; k++) begin
      tick();
      if (prev_ready) acc2 = k;
      if (out_valid && !got1) begin
        got1 = 1'b1;
        lat1 = k;
        ct1  = cipher_text;
      end
      prev_ready = in_ready;
    end
    in_valid = 1'b0;
    check("b2b_interval", 128'(acc2), 128'd12);
    check("b2b_lat1", 128'(lat1), 128'd10);
    check("b2b_ct1", ct1, C1_CT);
    wait_out(lat);
    check("b2b_lat2", 128'(lat), 128'd10);
    check("b2b_ct2", cipher_text, ref_encrypt(pt_b2, ek_c1));
    tick();
    out_ready = 1'b0;
    check("b2b_drained", 128'(out_valid), 128'd0);

`ifdef AES_ENC_KEY_LATCH_EN
    send("latch", C1_PT, ek_c1);
    tick();
    expanded_key = '1;
    wait_out(lat);
    check("latch_latency", 128'(lat), 128'd9);
    check("latch_ct", cipher_text, C1_CT);
    handshake("latch");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
- Iterative AES-128 encryption core: one round per clock, using a single shared round datapath.
- Forward-direction counterpart of the team's combinational AES decryption path.
- Consumes the same 1408-bit expanded key bus produced by keyExpansion, with the same round-key slicing.
- Valid/ready handshake on both the input and output sides, so it drops into streaming datapaths.

Parameters:
- NR, 10: number of rounds. Only 10 (AES-128) is supported; elaboration fails on any other value.
- KEY_BITS, 1408: expanded key width, defined as 128*(NR+1).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  plain_text and expanded_key are valid
- in_ready  output  1  core can accept a block
- plain_text  input  128  block to encrypt; bit 127 is the MSB of byte s0 (FIPS-197 column-major order)
- expanded_key  input  [0:1407]  round key r occupies bits [128r : 128r+127]; key0 is bits [0:127]
- out_valid  output  1  cipher_text is valid
- out_ready  input  1  downstream accepts cipher_text
- cipher_text  output  128  encrypted block, same byte order as plain_text
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset values: state=IDLE, round counter=0, state register=0, cipher_text=0, out_valid=0, in_ready=0 during the reset cycle, busy=0.
- in_ready is 1 in the first cycle after rst deasserts.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE). It is a registered decode with no combinational path from out_ready.
- IDLE, on in_valid&&in_ready at edge T:
  - state register <= plain_text ^ key0;
  - round <= 1;
  - go to RUN.
- RUN, round r in 1..9: state register <= MixColumns(ShiftRows(SubBytes(s))) ^ key[r]; round <= r+1.
- RUN, round 10: result = ShiftRows(SubBytes(s)) ^ key10, with no MixColumns.
  - cipher_text <= result; out_valid <= 1; go to DONE.
- Latency: out_valid rises at edge T+10, i.e. 10 cycles after the accepting edge. Minimum initiation interval is 12 cycles (accept, 9+1 rounds, output handshake, return to IDLE).
- DONE:
  - cipher_text and out_valid are held stable until out_valid&&out_ready.
  - On that handshake: out_valid <= 0, go to IDLE; in_ready=1 on the following cycle.
  - out_ready high on the same edge out_valid rises counts as the handshake only from the next edge.
- in_valid is ignored outside IDLE. No back-pressure is lost, and no input is queued.
- Round counter is 4 bits; values 11..15 are unreachable. If one is reached through an illegal state, the FSM returns to IDLE.
- Reset mid-operation (rst in RUN or DONE): the block is discarded and all outputs return to reset values on that edge. No partial result is ever presented.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.
- expanded_key handling without the optional feature: the key must be held stable from the accepting edge until out_valid. The core reads key[r] live each round.
- GF(2^8) arithmetic uses polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).

Optional Feature:
- Macro AES_ENC_KEY_LATCH_EN.
- Defined: a 1408-bit key register captures expanded_key on the accepting edge, and all rounds read the latched copy. The source may change expanded_key freely after acceptance.
- Undefined: no key register (saves 1408 flops). Stability of expanded_key through the run is the source's obligation. Latency and handshake are unchanged.

Decomposition:
- Package aes_pkg holds:
  - NR, BLOCK_BITS=128, KEY_BITS;
  - FSM state typedef (IDLE/RUN/DONE);
  - SBOX constant table and sbox() function;
  - xtime() and mix_column() functions.
- Sub-module aes_enc_round, combinational: inputs state, round_key, final_round. Output is SubBytes→ShiftRows→(MixColumns unless final_round)→AddRoundKey.
- aes_enc_round is instantiated once inside aes_encrypt_iter.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f expanded via keyExpansion, plain 00112233445566778899aabbccddeeff -> cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plain 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Backpressure: out_ready held 0 for 20 cycles after out_valid -> cipher_text constant, in_ready=0, pulses on in_valid ignored. Raise out_ready -> in_ready=1 on the next cycle.
- Reset mid-run: assert rst at round 5 -> next cycle out_valid=0, cipher_text=0, in_ready=1 after release. A new App. B block then yields the correct result.
- Back-to-back: two blocks with out_ready tied 1 -> second accept 12 cycles after the first, both results correct.
- With AES_ENC_KEY_LATCH_EN: change expanded_key to all-ones one cycle after accept -> C.1 result still 69c4e0d86a7b0430d8cdb78070b4c55a.
